// File: rtl/box_input_conditioner.sv
// Pad/start/super front end: 2-flop sync, per-channel debounce, legality filter
// and edge/level shaping for the game controller. `super` is a reserved word, so
// the debounced super level leaves on super_level.
module box_input_conditioner #(
  parameter int DB_LIMIT       = 50000,
  parameter int DB_CNT_W       = 16,
  parameter int MAX_ACTIVE     = 2,
  parameter int PAD_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] pad_raw,
  input  logic       start_raw,
  input  logic       super_raw,
  output logic [8:0] box,
  output logic       box_changed,
  output logic       start,
  output logic       super_level,
  output logic [3:0] active_count,
  output logic       overload
);

  // Channel map: [8:0] pads, [9] start, [10] super (super is never inverted).
  localparam int unsigned N = 11;
  localparam logic [N-1:0] INV_MASK = (PAD_ACTIVE_LOW != 0) ? {1'b0, {10{1'b1}}} : '0;
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);
  localparam logic [3:0] MAX_CNT = 4'(MAX_ACTIVE);

  logic [N-1:0]        raw;
  logic [N-1:0]        sync1;
  logic [N-1:0]        sync2;
  logic [N-1:0]        db;
  logic [DB_CNT_W-1:0] cnt [N];
  logic                start_db_q;
  logic [3:0]          pad_count;

  assign raw = {super_raw, start_raw, pad_raw} ^ INV_MASK;

  always_comb begin
    pad_count = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      pad_count = pad_count + {3'b000, db[i]};
    end
  end

  // A non-zero counter means the channel is pending; any agreement drops it back.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < N; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      box          <= '0;
      box_changed  <= 1'b0;
      start        <= 1'b0;
      start_db_q   <= 1'b0;
      super_level  <= 1'b0;
      active_count <= '0;
      overload     <= 1'b0;
    end else begin
      active_count <= pad_count;
      start_db_q   <= db[9];
      start        <= db[9] & ~start_db_q;
      super_level  <= db[10];
      // Over the limit, box freezes so the controller never sees an illegal press.
      if (pad_count <= MAX_CNT) begin
        box         <= db[8:0];
        box_changed <= (db[8:0] != box);
        overload    <= 1'b0;
      end else begin
        box_changed <= 1'b0;
        overload    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/box_input_conditioner.md
Name: box_input_conditioner

Overview:
- Front-end stage feeding the game controller: takes 9 raw pad inputs (3x3 grid), the start button and the super switch.
- Synchronizes and debounces all 11 inputs.
- Drives the controller's `box[8:0]` bitmap, a one-cycle `start` pulse and a clean `super` level.
- Rejects illegal multi-pad presses and flags `box` changes so collision checks see only settled values.

Parameters:
- DB_LIMIT, 50000, consecutive cycles a synchronized input must differ from its debounced value before the debounced value updates (≥2).
- DB_CNT_W, 16, width of each per-channel debounce counter; must hold DB_LIMIT-1.
- MAX_ACTIVE, 2, maximum simultaneously pressed pads accepted into `box`.
- PAD_ACTIVE_LOW, 0, 1 = `pad_raw`/`start_raw` are inverted before synchronization.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- pad_raw  input  9  asynchronous pad contacts, bit i = grid cell i.
- start_raw  input  1  asynchronous start button.
- super_raw  input  1  asynchronous super-mode switch (not inverted by PAD_ACTIVE_LOW).
- box  output  9  debounced, legality-filtered pad bitmap to the game controller.
- box_changed  output  1  one-cycle pulse on the edge `box` takes a new value.
- start  output  1  one-cycle pulse on debounced start rising edge.
- super  output  1  debounced super level.
- active_count  output  4  popcount of debounced pads (0..9), unfiltered.
- overload  output  1  level: debounced pad count > MAX_ACTIVE.

Behaviour:
- Reset (synchronous, active-high):
  - On any rising edge with `rst`=1, all sync flops, debounced values, counters, `box`, `box_changed`, `start`, `super`, `active_count` and `overload` are cleared to 0.
  - Mid-operation reset discards in-progress debounce counts. No output pulse is generated on reset release.
- Input conditioning:
  - Optional inversion per PAD_ACTIVE_LOW.
  - 2-flop synchronizer per channel (11 channels).
- Debounce, per channel, independent:
  - If sync value equals debounced value: counter <= 0.
  - Otherwise, if counter == DB_LIMIT-1: debounced <= sync value and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any single cycle of agreement restarts the count, so glitches shorter than DB_LIMIT cycles never propagate.
- Latency: raw input changes before edge 1 and is held stable:
  - Debounced value updates at edge DB_LIMIT+2.
  - `box`, `start`, `super`, `active_count` and `overload` update at edge DB_LIMIT+3.
- `active_count`: registered popcount of the 9 debounced pad bits.
- Legality filter:
  - If popcount(debounced pads) ≤ MAX_ACTIVE: `box` <= debounced pads and `overload` <= 0.
  - Otherwise: `box` holds its previous value and `overload` <= 1.
  - When the count returns ≤ MAX_ACTIVE, `box` takes the new debounced value on the next edge.
- `box_changed`: high for exactly one cycle, the cycle after the edge where `box` changed value. Never high when `box` is unchanged, including while held under overload.
- `start`:
  - Pulses for one cycle on the cycle after debounced start goes 0→1.
  - Release generates nothing.
  - Holding the button generates no further pulses.
- `super`: registered copy of debounced super; no edge detection.
- Simultaneous events: channels settle independently; several pad bits may change in the same edge, producing a single `box_changed` pulse.
- State summary: each channel is a two-state FSM.
  - STABLE: counter = 0.
  - PENDING: counter > 0, sync ≠ debounced.
  - PENDING → STABLE either on agreement (no update) or on reaching DB_LIMIT-1 (update).

Test Plan (DB_LIMIT=4, MAX_ACTIVE=2, PAD_ACTIVE_LOW=0):
- Reset then idle → all outputs 0. Assert `rst` mid-PENDING with `pad_raw[4]`=1 held 3 cycles → after reset, `box` stays 0 until 4 further stable cycles plus sync latency.
- `pad_raw`=9'b000010000 held from before edge 1 → `box`=9'b000010000 at edge 7. `box_changed`=1 for exactly one cycle after edge 7. `active_count`=1.
- `pad_raw[0]` pulse of 3 cycles (glitch) → `box` stays 0, `box_changed` never asserts. Bouncing 1/0/1/1/1/1 → update only after 4 consecutive differing synced cycles.
- `pad_raw`=9'b000000011, then 9'b100000011 → `box` holds 9'b000000011, `overload`=1, `active_count`=3, no `box_changed`. Release bit 8 → `overload`=0 and `box` unchanged with no pulse. Then `pad_raw`=9'b000000001 → `box`=9'b000000001 with one pulse.
- `start_raw` held high 20 cycles → exactly one `start` pulse at edge 7. Release and re-press → second single pulse.
- `super_raw` high → `super`=1 at edge 7, remains while held. `start_raw` and `super_raw` toggled on the same cycle → both outputs update on the same edge.
